// File: rtl/relu_neuron_backprop.sv
// rtl/relu_neuron_backprop.sv - ReLU neuron backward pass streaming per-input weight/input gradients
module relu_neuron_backprop #(
    parameter int  PREV_LAYER_OUTPUTS = 4,
    localparam int N  = PREV_LAYER_OUTPUTS,
    localparam int IW = (PREV_LAYER_OUTPUTS > 1) ? $clog2(PREV_LAYER_OUTPUTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [31:0]    grad_in,
    input  logic signed [31:0]    neuron_out,
    input  logic [N-1:0][31:0]    data_inputs,
    input  logic [N-1:0][31:0]    weights,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IW-1:0]         out_idx,
    output logic signed [31:0]    grad_weight,
    output logic signed [31:0]    grad_input,
    output logic signed [31:0]    grad_bias,
    output logic                  done
);

    // Operand storage is padded to a power of two so out_idx can address it with no range gaps.
    localparam int DEPTH = 1 << IW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;

    logic signed [31:0] grad_in_q;
    logic signed [31:0] neuron_out_q;
    logic signed [31:0] x_q [DEPTH];
    logic signed [31:0] w_q [DEPTH];
    logic signed [31:0] x_pad [DEPTH];
    logic signed [31:0] w_pad [DEPTH];

    logic               start_take;
    logic               accept;
    logic               last;
    logic [IW-1:0]      idx_next;
    logic signed [31:0] delta_new;
    logic signed [31:0] delta_reg;
    logic signed [31:0] op_delta;
    logic signed [31:0] op_x;
    logic signed [31:0] op_w;
    logic signed [31:0] gw_next;
    logic signed [31:0] gi_next;

    // Q7.24 multiply: full 64-bit signed product, keep bits [55:24], wrap on overflow.
    function automatic logic signed [31:0] qmul(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        logic signed [63:0] ae;
        logic signed [63:0] be;
        logic signed [63:0] p;
        ae = a;
        be = b;
        p  = ae * be;
        return 32'(p >>> 24);
    endfunction

    // Zero-extend the operand vectors into the padded storage width.
    for (genvar g = 0; g < DEPTH; g++) begin : g_pad
        if (g < N) begin : g_in
            assign x_pad[g] = $signed(data_inputs[g]);
            assign w_pad[g] = $signed(weights[g]);
        end else begin : g_zero
            assign x_pad[g] = '0;
            assign w_pad[g] = '0;
        end
    end

    assign busy = (state != S_IDLE);

    // One shared multiplier pair: the start cycle uses live inputs (pair 0), later pairs use stored operands.
    always_comb begin
        start_take = (state == S_IDLE) && start;
        accept     = (state == S_RUN) && out_valid && out_ready;
        last       = (out_idx == IW'(N - 1));
        idx_next   = start_take ? '0 : out_idx + 1'b1;
        delta_new  = (neuron_out > 0) ? grad_in : 32'sd0;
        delta_reg  = (neuron_out_q > 0) ? grad_in_q : 32'sd0;
        op_delta   = start_take ? delta_new : delta_reg;
        op_x       = start_take ? x_pad[0] : x_q[idx_next];
        op_w       = start_take ? w_pad[0] : w_q[idx_next];
        gw_next    = qmul(op_delta, op_x);
        gi_next    = qmul(op_delta, op_w);
    end

    // Pass controller: captures operands on start, steps k on each handshake, pulses done at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            out_idx      <= '0;
            grad_weight  <= '0;
            grad_input   <= '0;
            grad_bias    <= '0;
            grad_in_q    <= '0;
            neuron_out_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start_take) begin
                        grad_in_q    <= grad_in;
                        neuron_out_q <= neuron_out;
                        for (int i = 0; i < DEPTH; i++) begin
                            x_q[i] <= x_pad[i];
                            w_q[i] <= w_pad[i];
                        end
                        grad_bias   <= delta_new;
                        out_idx     <= '0;
                        grad_weight <= gw_next;
                        grad_input  <= gi_next;
                        out_valid   <= 1'b1;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            out_idx     <= idx_next;
                            grad_weight <= gw_next;
                            grad_input  <= gi_next;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
